frame_tx_scheduler: RTL and testbench

Sequences the transmit frame datapath in the clk_sys domain. It arbitrates between a high-rate sensor-data word source and a low-rate housekeeping word source. It inserts heartbeat words when the link has been idle too long. It presents one tagged 32-bit word at a time to the downstream frame packer/serializer through a valid/ready handshake.

---
 rtl/frame_tx_scheduler.sv | 110 +++++++++++
 tb/tb_frame_tx_scheduler.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_tx_scheduler.sv
// frame_tx_scheduler: arbitrates data/housekeeping words, inserts heartbeats, holds one tagged word for the packer; SCHED_STATS_EN adds grant counters
module frame_tx_scheduler #(
  parameter int unsigned HK_STARVE_MAX = 8,
  parameter int unsigned HB_GAP        = 4096,
  parameter logic [15:0] HB_PATTERN    = 16'hC0DE
) (
  input  logic        clk_sys,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [31:0] data_in,
  input  logic        data_valid,
  output logic        data_ready,
  input  logic [31:0] hk_in,
  input  logic        hk_valid,
  output logic        hk_ready,
  output logic [31:0] out_data,
  output logic [1:0]  out_tag,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        busy,
  output logic [15:0] hb_seq,
  output logic [15:0] stat_data_cnt,
  output logic [15:0] stat_hk_cnt,
  output logic [15:0] stat_hb_cnt
);
  typedef enum logic {IDLE, HOLD} state_e;
  localparam logic [7:0]  STARVE_MAX = 8'(HK_STARVE_MAX);
  localparam logic [15:0] GAP        = 16'(HB_GAP);
  localparam logic [1:0]  TAG_DATA   = 2'b00;
  localparam logic [1:0]  TAG_HK     = 2'b01;
  localparam logic [1:0]  TAG_HB     = 2'b10;
  state_e      state_q, state_d;
  logic [31:0] out_data_q, out_data_d;
  logic [1:0]  out_tag_q, out_tag_d;
  logic [7:0]  starve_q, starve_d;
  logic [15:0] idle_q, idle_d;
  logic [15:0] hb_seq_q, hb_seq_d;
  logic        can_grant, force_hk, grant_data, grant_hk, grant_hb, grant, accept;
  assign can_grant  = state_q == IDLE && enable;
  assign force_hk   = hk_valid && starve_q == STARVE_MAX;
  assign grant_data = can_grant && data_valid && !force_hk;
  assign grant_hk   = can_grant && hk_valid && !grant_data;
  assign grant_hb   = can_grant && !data_valid && !hk_valid && GAP != 16'd0 && idle_q == GAP;
  assign grant      = grant_data || grant_hk || grant_hb;
  assign accept     = state_q == HOLD && out_ready;
  assign data_ready = grant_data;
  assign hk_ready   = grant_hk;
  assign out_data   = out_data_q;
  assign out_tag    = out_tag_q;
  assign out_valid  = state_q == HOLD;
  assign busy       = state_q == HOLD;
  assign hb_seq     = hb_seq_q;
  // State and datapath registers; reset discards any held word
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      out_data_q <= '0;
      out_tag_q  <= '0;
      starve_q   <= '0;
      idle_q     <= '0;
      hb_seq_q   <= '0;
    end else begin
      state_q    <= state_d;
      out_data_q <= out_data_d;
      out_tag_q  <= out_tag_d;
      starve_q   <= starve_d;
      idle_q     <= idle_d;
      hb_seq_q   <= hb_seq_d;
    end
  end
  // Next state: load the granted word into HOLD, release it on handshake, track starvation and idle time
  always_comb begin
    state_d    = state_q;
    out_data_d = out_data_q;
    out_tag_d  = out_tag_q;
    hb_seq_d   = hb_seq_q;
    if (accept) begin
      state_d  = IDLE;
      hb_seq_d = out_tag_q == TAG_HB ? hb_seq_q + 16'd1 : hb_seq_q;
    end else if (grant) begin
      state_d    = HOLD;
      out_data_d = grant_data ? data_in : grant_hk ? hk_in : {HB_PATTERN, hb_seq_q};
      out_tag_d  = grant_data ? TAG_DATA : grant_hk ? TAG_HK : TAG_HB;
    end
    starve_d = (!hk_valid || grant_hk) ? 8'd0 : (grant_data && starve_q != STARVE_MAX) ? starve_q + 8'd1 : starve_q;
    idle_d   = (state_q == HOLD || !enable || grant) ? 16'd0 : idle_q != GAP ? idle_q + 16'd1 : idle_q;
  end
`ifdef SCHED_STATS_EN
  logic [15:0] stat_data_q, stat_hk_q, stat_hb_q;
  // Count words actually handed to the packer, by tag
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      stat_data_q <= '0;
      stat_hk_q   <= '0;
      stat_hb_q   <= '0;
    end else if (accept) begin
      stat_data_q <= out_tag_q == TAG_DATA ? stat_data_q + 16'd1 : stat_data_q;
      stat_hk_q   <= out_tag_q == TAG_HK ? stat_hk_q + 16'd1 : stat_hk_q;
      stat_hb_q   <= out_tag_q == TAG_HB ? stat_hb_q + 16'd1 : stat_hb_q;
    end
  end
  assign stat_data_cnt = stat_data_q;
  assign stat_hk_cnt   = stat_hk_q;
  assign stat_hb_cnt   = stat_hb_q;
`else
  assign stat_data_cnt = 16'h0000;
  assign stat_hk_cnt   = 16'h0000;
  assign stat_hb_cnt   = 16'h0000;
`endif
endmodule

// File: tb/tb_frame_tx_scheduler.sv
// tb_frame_tx_scheduler: directed vectors, corner sequences and randomized traffic against a reference model
module tb_frame_tx_scheduler;
  localparam int STARVE = 8;
  localparam int GAP    = 16;
  logic        clk_sys = 0, rst_n = 0, enable = 0, data_valid = 0, hk_valid = 0, out_ready = 0;
  logic [31:0] data_in = 0, hk_in = 0;
  logic        data_ready, hk_ready, out_valid, busy;
  logic [31:0] out_data;
  logic [1:0]  out_tag;
  logic [15:0] hb_seq, stat_data_cnt, stat_hk_cnt, stat_hb_cnt;
  logic        z_dr, z_hr, z_ov, z_busy, z_seen = 0;
  logic [31:0] z_od;
  logic [1:0]  z_tag;
  logic [15:0] z_seq, z_s0, z_s1, z_s2;
  int checks = 0, failures = 0;
  bit          m_busy;
  logic [31:0] m_data;
  logic [1:0]  m_tag;
  int          m_starve, m_idle, m_last;
  logic [15:0] m_hbseq;
  logic [15:0] m_stat [3];
  typedef struct {
    bit en; bit dv; logic [31:0] din; bit hv; logic [31:0] hin; bit ordy;
    bit e_dr; bit e_hr; bit e_ov; logic [31:0] e_od; logic [1:0] e_tag;
  } vec_t;
  vec_t tbl [13];

  always #5 clk_sys = ~clk_sys;

  frame_tx_scheduler #(.HK_STARVE_MAX(STARVE), .HB_GAP(GAP), .HB_PATTERN(16'hC0DE)) dut (
    .clk_sys(clk_sys), .rst_n(rst_n), .enable(enable), .data_in(data_in), .data_valid(data_valid),
    .data_ready(data_ready), .hk_in(hk_in), .hk_valid(hk_valid), .hk_ready(hk_ready),
    .out_data(out_data), .out_tag(out_tag), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .hb_seq(hb_seq), .stat_data_cnt(stat_data_cnt), .stat_hk_cnt(stat_hk_cnt),
    .stat_hb_cnt(stat_hb_cnt));

  frame_tx_scheduler #(.HK_STARVE_MAX(STARVE), .HB_GAP(0), .HB_PATTERN(16'hC0DE)) dut_nohb (
    .clk_sys(clk_sys), .rst_n(rst_n), .enable(1'b1), .data_in(32'h0), .data_valid(1'b0),
    .data_ready(z_dr), .hk_in(32'h0), .hk_valid(1'b0), .hk_ready(z_hr),
    .out_data(z_od), .out_tag(z_tag), .out_valid(z_ov), .out_ready(1'b1),
    .busy(z_busy), .hb_seq(z_seq), .stat_data_cnt(z_s0), .stat_hk_cnt(z_s1), .stat_hb_cnt(z_s2));

  always @(negedge clk_sys) if (z_ov) z_seen = 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // 0 data, 1 housekeeping, 2 heartbeat, 3 nothing granted
  function automatic int pick();
    if (m_busy || !enable) return 3;
    if (hk_valid && m_starve == STARVE) return 1;
    if (data_valid) return 0;
    if (hk_valid) return 1;
    if (GAP != 0 && m_idle == GAP) return 2;
    return 3;
  endfunction

  task automatic model_clear();
    m_busy = 0; m_data = 0; m_tag = 0; m_starve = 0; m_idle = 0; m_hbseq = 0; m_last = 3;
    for (int i = 0; i < 3; i++) m_stat[i] = 0;
  endtask

  task automatic model_check();
    int g = pick();
    chk("data_ready", 32'(g == 0), 32'(data_ready));
    chk("hk_ready", 32'(hk_ready), 32'(g == 1));
    chk("out_valid", 32'(out_valid), 32'(m_busy));
    chk("busy", 32'(busy), 32'(m_busy));
    chk("hb_seq", 32'(hb_seq), 32'(m_hbseq));
    if (m_busy) begin
      chk("out_data", out_data, m_data);
      chk("out_tag", 32'(out_tag), 32'(m_tag));
    end
`ifdef SCHED_STATS_EN
    chk("stat_data", 32'(stat_data_cnt), 32'(m_stat[0]));
    chk("stat_hk", 32'(stat_hk_cnt), 32'(m_stat[1]));
    chk("stat_hb", 32'(stat_hb_cnt), 32'(m_stat[2]));
`else
    chk("stat_data", 32'(stat_data_cnt), 32'h0);
    chk("stat_hk", 32'(stat_hk_cnt), 32'h0);
    chk("stat_hb", 32'(stat_hb_cnt), 32'h0);
`endif
  endtask

  task automatic model_step();
    int g = pick();
    bit was_busy = m_busy;
    if (m_busy && out_ready) begin
      m_busy = 0;
      if (m_tag == 2) m_hbseq++;
      m_stat[m_tag]++;
    end
    m_starve = (!hk_valid || g == 1) ? 0 : (g == 0 && m_starve < STARVE) ? m_starve + 1 : m_starve;
    m_idle = (was_busy || !enable || g != 3) ? 0 : (m_idle < GAP) ? m_idle + 1 : m_idle;
    if (g != 3) begin
      m_busy = 1;
      m_tag = 2'(g);
      m_data = g == 0 ? data_in : g == 1 ? hk_in : {16'hC0DE, m_hbseq};
    end
    m_last = g;
  endtask

  task automatic finish_cycle();
    @(posedge clk_sys);
    model_step();
    #1;
  endtask

  task automatic cycle();
    @(negedge clk_sys);
    model_check();
    finish_cycle();
  endtask

  task automatic do_reset();
    rst_n = 0;
    model_clear();
    repeat (2) @(posedge clk_sys);
    #1 rst_n = 1;
  endtask

  task automatic wait_hb(input logic [31:0] exp_od);
    int n = 0;
    while (n < 100) begin
      @(negedge clk_sys);
      model_check();
      if (out_valid) break;
      finish_cycle();
      n++;
    end
    chk("hb_latency", 32'(n), 32'd17);
    chk("hb_data", out_data, exp_od);
    chk("hb_tag", 32'(out_tag), 32'd2);
    finish_cycle();
  endtask

  initial begin
    tbl[0]  = '{1, 1, 32'h12345678, 0, 32'h0,        1, 1, 0, 0, 32'h0,        2'd0};
    tbl[1]  = '{1, 0, 32'h0,        0, 32'h0,        1, 0, 0, 1, 32'h12345678, 2'd0};
    tbl[2]  = '{1, 0, 32'h0,        0, 32'h0,        1, 0, 0, 0, 32'h0,        2'd0};
    tbl[3]  = '{1, 0, 32'h0,        1, 32'hAABBCCDD, 0, 0, 1, 0, 32'h0,        2'd0};
    tbl[4]  = '{1, 0, 32'h0,        0, 32'h0,        0, 0, 0, 1, 32'hAABBCCDD, 2'd1};
    tbl[5]  = '{1, 1, 32'h1,        0, 32'h0,        0, 0, 0, 1, 32'hAABBCCDD, 2'd1};
    tbl[6]  = '{1, 1, 32'h1,        0, 32'h0,        1, 0, 0, 1, 32'hAABBCCDD, 2'd1};
    tbl[7]  = '{1, 1, 32'h1,        0, 32'h0,        0, 1, 0, 0, 32'h0,        2'd0};
    tbl[8]  = '{0, 0, 32'h0,        0, 32'h0,        0, 0, 0, 1, 32'h1,        2'd0};
    tbl[9]  = '{0, 1, 32'h2,        0, 32'h0,        1, 0, 0, 1, 32'h1,        2'd0};
    tbl[10] = '{0, 1, 32'h2,        0, 32'h0,        1, 0, 0, 0, 32'h0,        2'd0};
    tbl[11] = '{1, 0, 32'h0,        1, 32'h5,        1, 0, 1, 0, 32'h0,        2'd0};
    tbl[12] = '{1, 0, 32'h0,        0, 32'h0,        1, 0, 0, 1, 32'h5,        2'd1};

    do_reset();
    @(negedge clk_sys);
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_out_data", out_data, 32'h0);
    chk("rst_out_tag", 32'(out_tag), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_hb_seq", 32'(hb_seq), 32'h0);
    model_check();
    finish_cycle();

    for (int i = 0; i < 13; i++) begin
      enable = tbl[i].en; data_valid = tbl[i].dv; data_in = tbl[i].din;
      hk_valid = tbl[i].hv; hk_in = tbl[i].hin; out_ready = tbl[i].ordy;
      @(negedge clk_sys);
      chk($sformatf("vec%0d_data_ready", i), 32'(data_ready), 32'(tbl[i].e_dr));
      chk($sformatf("vec%0d_hk_ready", i), 32'(hk_ready), 32'(tbl[i].e_hr));
      chk($sformatf("vec%0d_out_valid", i), 32'(out_valid), 32'(tbl[i].e_ov));
      if (tbl[i].e_ov) begin
        chk($sformatf("vec%0d_out_data", i), out_data, tbl[i].e_od);
        chk($sformatf("vec%0d_out_tag", i), 32'(out_tag), 32'(tbl[i].e_tag));
      end
      model_check();
      finish_cycle();
    end

    data_valid = 1; data_in = 32'hCAFEF00D; hk_valid = 0; out_ready = 0;
    cycle();
    for (int i = 0; i < 10; i++) begin
      data_in = 32'hDEAD0000 + 32'(i);
      @(negedge clk_sys);
      chk("hold_data", out_data, 32'hCAFEF00D);
      chk("hold_tag", 32'(out_tag), 32'h0);
      chk("hold_ready", 32'(data_ready), 32'h0);
      chk("hold_busy", 32'(busy), 32'h1);
      model_check();
      finish_cycle();
    end
    data_valid = 0; out_ready = 1;
    cycle();
    @(negedge clk_sys);
    chk("hold_released", 32'(out_valid), 32'h0);
    model_check();
    finish_cycle();

    begin
      int n = 0;
      data_valid = 1; hk_valid = 1; data_in = 32'h11110000; hk_in = 32'h22220000;
      for (int c = 0; c < 54; c++) begin
        @(negedge clk_sys);
        model_check();
        if (out_valid) begin
          chk($sformatf("starve_tag%0d", n), 32'(out_tag), (n % 9 == 8) ? 32'd1 : 32'd0);
          n++;
        end
        finish_cycle();
      end
      chk("starve_words", 32'(n), 32'd27);
      data_valid = 0; hk_valid = 0;
    end

    do_reset();
    enable = 1; out_ready = 1;
    wait_hb(32'hC0DE0000);
    wait_hb(32'hC0DE0001);
    repeat (10) cycle();
    enable = 0;
    data_valid = 1; data_in = 32'h99;
    repeat (3) begin
      @(negedge clk_sys);
      chk("disabled_ready", 32'(data_ready), 32'h0);
      model_check();
      finish_cycle();
    end
    data_valid = 0; enable = 1;
    wait_hb(32'hC0DE0002);

    do_reset();
    enable = 1; out_ready = 1;
    for (int i = 0; i < 5; i++) begin
      data_valid = 1; data_in = 32'(i) + 32'h100;
      cycle();
      data_valid = 0;
      cycle();
    end
    for (int i = 0; i < 2; i++) begin
      hk_valid = 1; hk_in = 32'(i) + 32'h200;
      cycle();
      hk_valid = 0;
      cycle();
    end
    wait_hb(32'hC0DE0000);
    @(negedge clk_sys);
`ifdef SCHED_STATS_EN
    chk("stats_data", 32'(stat_data_cnt), 32'd5);
    chk("stats_hk", 32'(stat_hk_cnt), 32'd2);
    chk("stats_hb", 32'(stat_hb_cnt), 32'd1);
`else
    chk("stats_data", 32'(stat_data_cnt), 32'd0);
    chk("stats_hk", 32'(stat_hk_cnt), 32'd0);
    chk("stats_hb", 32'(stat_hb_cnt), 32'd0);
`endif
    model_check();
    finish_cycle();

    out_ready = 0; data_valid = 1; data_in = 32'h77;
    cycle();
    data_valid = 0;
    @(negedge clk_sys);
    chk("midhold_valid", 32'(out_valid), 32'h1);
    rst_n = 0;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'h0);
    chk("midrst_busy", 32'(busy), 32'h0);
    chk("midrst_hb_seq", 32'(hb_seq), 32'h0);
    chk("midrst_stat_data", 32'(stat_data_cnt), 32'h0);
    chk("midrst_stat_hk", 32'(stat_hk_cnt), 32'h0);
    chk("midrst_stat_hb", 32'(stat_hb_cnt), 32'h0);
    do_reset();

    for (int i = 0; i < 3000; i++) begin
      int pd = ((i / 500) % 2) ? 4 : 50;
      int ph = ((i / 500) % 2) ? 2 : 15;
      if (!(data_valid && m_last != 0)) begin
        data_valid = $urandom_range(0, 99) < pd;
        data_in = $urandom;
      end
      if (!(hk_valid && m_last != 1)) begin
        hk_valid = $urandom_range(0, 99) < ph;
        hk_in = $urandom;
      end
      enable = $urandom_range(0, 99) < 97;
      out_ready = $urandom_range(0, 99) < 60;
      cycle();
    end

    chk("gap0_no_output", 32'(z_seen), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
